// File: rtl/mips_alu_pkg.sv
// Shared constants for the MIPS ALU control / multiply-divide block:
// funct codes, ALU control codes, md FSM state encoding, divide-by-zero
// fill value and the combinational ALU control decode.
package mips_alu_pkg;

    // aluop values from main control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // R-type ALU funct codes
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // R-type multiply/divide and HI/LO move funct codes
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // ALU control codes driven on gout
    localparam logic [3:0] G_AND  = 4'b0000;
    localparam logic [3:0] G_OR   = 4'b0001;
    localparam logic [3:0] G_ADD  = 4'b0010;
    localparam logic [3:0] G_XOR  = 4'b0011;
    localparam logic [3:0] G_SUB  = 4'b0110;
    localparam logic [3:0] G_SLT  = 4'b0111;
    localparam logic [3:0] G_SLTU = 4'b1000;
    localparam logic [3:0] G_NOR  = 4'b1100;
    localparam logic [3:0] G_NONE = 4'b1111;

    // Multiply/divide sequencer states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_FIXUP = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // Divide by zero: every LO bit takes this value; HI receives the
    // dividend exactly as issued (no sign handling applied).
    localparam logic DIV0_QUOT_FILL = 1'b1;

    // ALU control decode shared by every build of the block
    function automatic logic [3:0] decode_gout(input logic [1:0] aluop,
                                               input logic [5:0] funct);
        logic [3:0] code;
        code = G_NONE;
        case (aluop)
            ALUOP_ADD: code = G_ADD;
            ALUOP_SUB: code = G_SUB;
            ALUOP_OR:  code = G_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  code = G_ADD;
                    FN_SUB:  code = G_SUB;
                    FN_AND:  code = G_AND;
                    FN_OR:   code = G_OR;
                    FN_XOR:  code = G_XOR;
                    FN_NOR:  code = G_NOR;
                    FN_SLT:  code = G_SLT;
                    FN_SLTU: code = G_SLTU;
                    default: code = G_NONE;
                endcase
            end
            default: code = G_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned multiply / restoring divide engine.
// Takes one bit per cycle for WIDTH cycles after start; done_iter is high
// during the final iteration cycle so the results are stable the cycle after.
// Build option: ALUCONT_MD_DIV_EN includes the restoring divider step;
// without it only the shift-add multiplier is built and is_div is ignored.
module md_iter_core
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_iter,
    output logic [WIDTH-1:0] hi_raw,
    output logic [WIDTH-1:0] lo_raw
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // r_acc: running partial product high half / partial remainder
    // r_q:   multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;

`ifdef ALUCONT_MD_DIV_EN
    logic             r_is_div;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
`else
    logic             w_unused_is_div;
    assign w_unused_is_div = is_div;
`endif

    assign done_iter = r_active && (r_cnt == CNT_W'(WIDTH - 1));
    assign hi_raw    = r_acc;
    assign lo_raw    = r_q;

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_acc_nxt = w_mul_sum[WIDTH:1];
        w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
`ifdef ALUCONT_MD_DIV_EN
        w_div_shift = {r_acc, r_q[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
        if (r_is_div) begin
            // Top bit of the (WIDTH+1)-bit difference clear means it fits
            if (!w_div_diff[WIDTH]) begin
                w_acc_nxt = w_div_diff[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_div_shift[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = w_mul_sum[WIDTH:1];
            w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
`endif
    end

    // Operand load on start, then one step per cycle until the count expires
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
`ifdef ALUCONT_MD_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else if (start) begin
            r_acc    <= '0;
            r_q      <= a;
            r_b      <= b;
            r_cnt    <= '0;
            r_active <= 1'b1;
`ifdef ALUCONT_MD_DIV_EN
            r_is_div <= is_div;
`endif
        end else if (r_active) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            if (done_iter) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alucont_md.sv
// ALU control decode plus sequenced multiply/divide unit with HI/LO.
// gout, md_rd and stall are combinational; HI/LO, md_busy and md_done are
// registered. A start op launches a WIDTH-cycle iteration followed by a
// sign fix-up cycle; HI/LO are written on entry to DONE.
// Build option: ALUCONT_MD_DIV_EN enables div/divu; without it funct
// 0x1A/0x1B are treated as invalid (gout=1111, no start, no stall).
module alucont_md
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       gout,
    output logic [WIDTH-1:0] md_rd,
    output logic             md_busy,
    output logic             md_done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_md_busy;
    logic             r_md_done;
    logic             r_is_div;
    logic             r_neg_res;   // product / quotient negated
    logic             r_neg_rem;   // remainder negated (dividend sign)
    logic             r_div_zero;
    logic [WIDTH-1:0] r_dividend;

    logic             w_rtype;
    logic             w_is_mult;
    logic             w_is_divop;
    logic             w_is_start;
    logic             w_is_signed;
    logic             w_is_mf;
    logic             w_is_mt;
    logic             w_md_any;
    logic             w_accept;
    logic             w_start;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_done_iter;
    logic [WIDTH-1:0] w_hi_raw;
    logic [WIDTH-1:0] w_lo_raw;
    logic [PW-1:0]    w_prod_mag;
    logic [PW-1:0]    w_prod_neg;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_lo_fix;

    // Instruction classification
    assign w_rtype   = (aluop == ALUOP_RTYPE);
    assign w_is_mult = w_rtype && ((funct == FN_MULT) || (funct == FN_MULTU));
`ifdef ALUCONT_MD_DIV_EN
    assign w_is_divop = w_rtype && ((funct == FN_DIV) || (funct == FN_DIVU));
`else
    assign w_is_divop = 1'b0;
`endif
    assign w_is_start  = w_is_mult || w_is_divop;
    assign w_is_signed = w_rtype && ((funct == FN_MULT) || (funct == FN_DIV));
    assign w_is_mf     = w_rtype && ((funct == FN_MFHI) || (funct == FN_MFLO));
    assign w_is_mt     = w_rtype && ((funct == FN_MTHI) || (funct == FN_MTLO));
    assign w_md_any    = w_is_start || w_is_mf || w_is_mt;

    // An md instruction is only taken while the sequencer is idle
    assign w_accept = valid && (r_state == ST_IDLE);
    assign w_start  = w_accept && w_is_start;
    assign stall    = valid && w_md_any && (r_state != ST_IDLE);

    // Operand magnitudes for signed ops; unsigned ops pass through raw
    assign w_mag_a = (w_is_signed && rs_val[WIDTH-1]) ? (~rs_val + WIDTH'(1)) : rs_val;
    assign w_mag_b = (w_is_signed && rt_val[WIDTH-1]) ? (~rt_val + WIDTH'(1)) : rt_val;

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign md_busy = r_md_busy;
    assign md_done = r_md_done;

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (w_start),
        .is_div    (w_is_divop),
        .a         (w_mag_a),
        .b         (w_mag_b),
        .done_iter (w_done_iter),
        .hi_raw    (w_hi_raw),
        .lo_raw    (w_lo_raw)
    );

    // ALU control code from aluop/funct
    always_comb begin
        gout = decode_gout(aluop, funct);
    end

    // HI/LO read port for mfhi/mflo
    always_comb begin
        md_rd = '0;
        if (w_rtype && (funct == FN_MFHI)) begin
            md_rd = r_hi;
        end else if (w_rtype && (funct == FN_MFLO)) begin
            md_rd = r_lo;
        end else begin
            md_rd = '0;
        end
    end

    assign w_prod_mag = {w_hi_raw, w_lo_raw};
    assign w_prod_neg = ~w_prod_mag + PW'(1);

    // Sign fix-up of the raw iteration results, consumed in FIXUP
    always_comb begin
        w_hi_fix = w_hi_raw;
        w_lo_fix = w_lo_raw;
        if (r_is_div) begin
            if (r_div_zero) begin
                w_lo_fix = {WIDTH{DIV0_QUOT_FILL}};
                w_hi_fix = r_dividend;
            end else begin
                w_lo_fix = r_neg_res ? (~w_lo_raw + WIDTH'(1)) : w_lo_raw;
                w_hi_fix = r_neg_rem ? (~w_hi_raw + WIDTH'(1)) : w_hi_raw;
            end
        end else begin
            if (r_neg_res) begin
                {w_hi_fix, w_lo_fix} = w_prod_neg;
            end else begin
                {w_hi_fix, w_lo_fix} = w_prod_mag;
            end
        end
    end

    // Sequencer FSM, HI/LO architectural state and busy/done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_md_busy  <= 1'b0;
            r_md_done  <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_dividend <= '0;
        end else begin
            r_md_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_RUN;
                        r_md_busy  <= 1'b1;
                        r_is_div   <= w_is_divop;
                        r_neg_res  <= w_is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        r_neg_rem  <= w_is_signed && rs_val[WIDTH-1];
                        r_div_zero <= (rt_val == '0);
                        r_dividend <= rs_val;
                    end else if (w_accept && w_is_mt) begin
                        if (funct == FN_MTHI) begin
                            r_hi <= rs_val;
                        end else begin
                            r_lo <= rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_done_iter) begin
                        r_state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    r_hi      <= w_hi_fix;
                    r_lo      <= w_lo_fix;
                    r_md_done <= 1'b1;
                    r_md_busy <= 1'b0;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alucont_md.sv
// Directed bench for alucont_md: a WIDTH=32 instance for decode, mult/div,
// stall and reset behaviour, and a WIDTH=8 instance for the narrow build.
module tb_alucont_md;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] rs_val, rt_val;
    logic [3:0]   gout;
    logic [W-1:0] md_rd, hi, lo;
    logic         md_busy, md_done, stall;

    logic         valid8;
    logic [1:0]   aluop8;
    logic [5:0]   funct8;
    logic [7:0]   rs8, rt8;
    logic [3:0]   gout8;
    logic [7:0]   md_rd8, hi8, lo8;
    logic         md_busy8, md_done8, stall8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alucont_md #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .valid(valid), .aluop(aluop), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .gout(gout), .md_rd(md_rd),
        .md_busy(md_busy), .md_done(md_done), .stall(stall), .hi(hi), .lo(lo)
    );

    alucont_md #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .valid(valid8), .aluop(aluop8), .funct(funct8),
        .rs_val(rs8), .rt_val(rt8), .gout(gout8), .md_rd(md_rd8),
        .md_busy(md_busy8), .md_done(md_done8), .stall(stall8), .hi(hi8), .lo(lo8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start op on the 32-bit unit and wait for md_done; lat is the
    // number of edges from the start edge (counted as 1), or -1 on timeout.
    task automatic issue_wait(input logic [5:0] fn, input logic [W-1:0] a,
                              input logic [W-1:0] b, output int lat);
        int k;
        aluop = 2'b10; funct = fn; rs_val = a; rt_val = b; valid = 1'b1;
        tick();
        valid = 1'b0;
        k = 1;
        while (!md_done && k < 60) begin
            tick();
            k++;
        end
        lat = md_done ? k : -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b0; aluop = 2'b00; funct = 6'h00;
        rs_val = '0; rt_val = '0;
        valid8 = 1'b0; aluop8 = 2'b00; funct8 = 6'h00; rs8 = 8'h00; rt8 = 8'h00;
        repeat (3) tick();
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        checks++; if ({md_busy, md_done, stall} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {md_busy, md_done, stall}); end
        checks++; if ({hi8, lo8, md_busy8, md_done8} !== 18'h0) begin errors++; $display("FAIL reset_w8: got %h expected 0", {hi8, lo8, md_busy8, md_done8}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_decode();
        logic [3:0] exp;
        int bad;
        valid = 1'b0; aluop = 2'b10; bad = 0;
        for (int f = 0; f < 64; f++) begin
            funct = f[5:0];
            #1;
            case (f)
                32: exp = 4'b0010;
                34: exp = 4'b0110;
                36: exp = 4'b0000;
                37: exp = 4'b0001;
                38: exp = 4'b0011;
                39: exp = 4'b1100;
                42: exp = 4'b0111;
                43: exp = 4'b1000;
                default: exp = 4'b1111;
            endcase
            checks++;
            if (gout !== exp) begin errors++; $display("FAIL decode_rtype funct=%h: got %b expected %b", f[5:0], gout, exp); end
        end
        funct = 6'h18;
        aluop = 2'b00; #1; checks++; if (gout !== 4'b0010) begin errors++; $display("FAIL decode_aluop00: got %b expected 0010", gout); end
        aluop = 2'b01; #1; checks++; if (gout !== 4'b0110) begin errors++; $display("FAIL decode_aluop01: got %b expected 0110", gout); end
        aluop = 2'b11; #1; checks++; if (gout !== 4'b0001) begin errors++; $display("FAIL decode_aluop11: got %b expected 0001", gout); end
        // mult funct with valid=0 must not start the unit
        aluop = 2'b10; funct = 6'h18;
        tick(); tick();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL start_without_valid: busy got %b expected 0", md_busy); end
    endtask

    task automatic test_mult();
        int lat;
        issue_wait(6'h18, 32'hFFFFFFFD, 32'h00000007, lat);
        checks++; if (lat !== W + 2) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", lat, W + 2); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected FFFFFFFF", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h expected FFFFFFEB", lo); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b expected 0", md_busy); end
        tick();
        checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", md_done); end
        issue_wait(6'h19, 32'hFFFFFFFD, 32'h00000007, lat);
        checks++; if (hi !== 32'h00000006) begin errors++; $display("FAIL multu_hi: got %h expected 00000006", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL multu_lo: got %h expected FFFFFFEB", lo); end
        tick();
    endtask

`ifdef ALUCONT_MD_DIV_EN
    task automatic test_div();
        int lat;
        issue_wait(6'h1A, 32'hFFFFFFF9, 32'h00000002, lat);
        checks++; if (lat !== W + 2) begin errors++; $display("FAIL div_latency: got %0d expected %0d", lat, W + 2); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_quot: got %h expected FFFFFFFD", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_rem: got %h expected FFFFFFFF", hi); end
        tick();
        issue_wait(6'h1B, 32'h00000064, 32'h00000007, lat);
        checks++; if ({hi, lo} !== {32'h00000002, 32'h0000000E}) begin errors++; $display("FAIL divu_100_7: got %h expected 000000020000000E", {hi, lo}); end
        tick();
        issue_wait(6'h1B, 32'h00000007, 32'h00000000, lat);
        checks++; if (lat !== W + 2) begin errors++; $display("FAIL div0_latency: got %0d expected %0d", lat, W + 2); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected FFFFFFFF", lo); end
        checks++; if (hi !== 32'h00000007) begin errors++; $display("FAIL div0_hi: got %h expected 00000007", hi); end
        tick();
    endtask
`else
    task automatic test_div_disabled();
        logic [W-1:0] hi_s, lo_s;
        hi_s = hi; lo_s = lo;
        aluop = 2'b10; funct = 6'h1A; rs_val = 32'h00000007; rt_val = 32'h00000002; valid = 1'b1;
        #1;
        checks++; if (gout !== 4'b1111) begin errors++; $display("FAIL nodiv_gout: got %b expected 1111", gout); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nodiv_stall: got %b expected 0", stall); end
        tick();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL nodiv_busy: got %b expected 0", md_busy); end
        valid = 1'b0;
        repeat (3) tick();
        checks++; if ({hi, lo} !== {hi_s, lo_s}) begin errors++; $display("FAIL nodiv_hilo: got %h expected %h", {hi, lo}, {hi_s, lo_s}); end
    endtask
`endif

    task automatic test_stall_mflo();
        int ok;
        aluop = 2'b10; funct = 6'h19; rs_val = 32'h00000005; rt_val = 32'h00000009; valid = 1'b1;
        tick();                                   // start edge (1)
        valid = 1'b0;
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", md_busy); end
        tick(); tick();                           // after edge 3
        funct = 6'h20; valid = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_no_stall: got %b expected 0", stall); end
        checks++; if (gout !== 4'b0010) begin errors++; $display("FAIL add_gout_busy: got %b expected 0010", gout); end
        valid = 1'b0;
        tick(); tick();                           // after edge 5
        funct = 6'h12; valid = 1'b1;
        ok = 1;
        for (int k = 5; k <= W + 2; k++) begin
            #1;
            if (stall !== 1'b1) ok = 0;
            if (k == W + 2) begin
                checks++; if (md_done !== 1'b1) begin errors++; $display("FAIL mflo_done_cycle: got %b expected 1", md_done); end
            end
            tick();
        end
        checks++; if (ok !== 1) begin errors++; $display("FAIL mflo_stall_window: got %0d expected 1", ok); end
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mflo_accept: stall got %b expected 0", stall); end
        checks++; if (md_rd !== 32'h0000002D) begin errors++; $display("FAIL mflo_rd: got %h expected 0000002D", md_rd); end
        valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        int k;
        issue_wait(6'h18, 32'h00000002, 32'h00000003, lat);
        checks++; if ({hi, lo} !== 64'h0000000000000006) begin errors++; $display("FAIL b2b_first: got %h expected 6", {hi, lo}); end
        aluop = 2'b10; funct = 6'h18; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF; valid = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall_done: got %b expected 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_idle_accept: got %b expected 0", stall); end
        tick();
        valid = 1'b0;
        k = 1;
        while (!md_done && k < 60) begin
            tick();
            k++;
        end
        checks++; if (k !== W + 2) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", k, W + 2); end
        checks++; if ({hi, lo} !== 64'h0000000000000001) begin errors++; $display("FAIL b2b_second: got %h expected 1", {hi, lo}); end
        tick();
    endtask

    task automatic test_reset_abort();
        int ok;
`ifdef ALUCONT_MD_DIV_EN
        aluop = 2'b10; funct = 6'h1A;
`else
        aluop = 2'b10; funct = 6'h18;
`endif
        rs_val = 32'h00000064; rt_val = 32'h00000007; valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (9) tick();                        // cycle T+10
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
        checks++; if ({md_busy, md_done} !== 2'b00) begin errors++; $display("FAIL abort_flags: got %b expected 00", {md_busy, md_done}); end
        aluop = 2'b10; funct = 6'h11; rs_val = 32'hA5A5A5A5; valid = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_idle: stall got %b expected 0", stall); end
        tick();
        valid = 1'b0;
        checks++; if (hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mthi_hi: got %h expected A5A5A5A5", hi); end
        checks++; if (lo !== 32'h00000000) begin errors++; $display("FAIL mthi_lo: got %h expected 0", lo); end
        ok = 1;
        for (int k = 0; k < W + 4; k++) begin
            if (md_done !== 1'b0 || md_busy !== 1'b0) ok = 0;
            tick();
        end
        checks++; if (ok !== 1) begin errors++; $display("FAIL abort_no_done: got %0d expected 1", ok); end
    endtask

    task automatic test_w8();
        int k;
        aluop8 = 2'b10; funct8 = 6'h18; rs8 = 8'h80; rt8 = 8'h80; valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
        k = 1;
        while (!md_done8 && k < 30) begin
            tick();
            k++;
        end
        checks++; if (k !== 10) begin errors++; $display("FAIL w8_latency: got %0d expected 10", k); end
        checks++; if ({hi8, lo8} !== 16'h4000) begin errors++; $display("FAIL w8_mult_80_80: got %h expected 4000", {hi8, lo8}); end
        tick();
        aluop8 = 2'b10; funct8 = 6'h18; rs8 = 8'h80; rt8 = 8'h01; valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
        k = 1;
        while (!md_done8 && k < 30) begin
            tick();
            k++;
        end
        checks++; if ({hi8, lo8} !== 16'hFF80) begin errors++; $display("FAIL w8_mult_80_01: got %h expected FF80", {hi8, lo8}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mult();
`ifdef ALUCONT_MD_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_stall_mflo();
        test_back_to_back();
        test_reset_abort();
        test_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
